// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a 1-bit SPR_W x SPR_H sprite from a synchronous ROM
// into a 1-bit framebuffer at (x0, y0). Only set pixels are written, so the
// sprite overlays whatever is already on screen. Off-screen pixels are dropped.
module sprite_blitter #(
  parameter int SPR_W = 20,
  parameter int SPR_H = 30,
  parameter int FB_W  = 320,
  parameter int FB_H  = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [7:0]  y0,
  output logic        busy,
  output logic        done,
  output logic [9:0]  rom_addr,
  input  logic        rom_pixel,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic        fb_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Counters track the (row, col) currently presented on rom_addr.
  logic [4:0]  row;
  logic [4:0]  col;
  logic [9:0]  rom_addr_reg;
  logic [8:0]  x_base;
  logic [7:0]  y_base;
  logic        last_pixel;

  // Stage 1 of the shadow is the live counter pair (aligned with rom_addr);
  // stage 2 is delayed one cycle so it lines up with rom_pixel.
  logic        s1_valid;
  logic        s2_valid;
  logic [4:0]  s2_row;
  logic [4:0]  s2_col;

  logic [9:0]  sx;
  logic [8:0]  sy;
  logic        on_screen;
  logic        wr_hit;
  logic [16:0] wr_addr;

  logic        done_next;
  logic        done_reg;
  logic        fb_we_reg;
  logic        fb_wdata_reg;
  logic [16:0] fb_addr_reg;

  assign last_pixel = (row == 5'(SPR_H - 1)) && (col == 5'(SPR_W - 1));
  assign s1_valid   = (state_reg == READ);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: one sweep of the ROM, then wait for the pipeline to empty.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)      state_next = READ;
      READ:    if (last_pixel) state_next = DRAIN;
      DRAIN:   if (!s2_valid)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Output decode: busy covers READ and DRAIN; done fires as DRAIN retires.
  always_comb begin
    busy      = (state_reg != IDLE);
    done_next = (state_reg == DRAIN) && !s2_valid;
  end

  // Address generator: latch origin on start, then step row-major through the ROM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row          <= '0;
      col          <= '0;
      rom_addr_reg <= '0;
      x_base       <= '0;
      y_base       <= '0;
    end else if (state_reg == IDLE && start) begin
      row          <= '0;
      col          <= '0;
      rom_addr_reg <= '0;
      x_base       <= x0;
      y_base       <= y0;
    end else if (state_reg == READ && !last_pixel) begin
      rom_addr_reg <= rom_addr_reg + 10'd1;
      if (col == 5'(SPR_W - 1)) begin
        col <= '0;
        row <= row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

  // Shadow stage 2: carry the coordinates across the ROM's read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_row   <= '0;
      s2_col   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_row   <= row;
      s2_col   <= col;
    end
  end

  // Screen coordinate, clip test and linear framebuffer address for stage 2.
  always_comb begin
    sx        = {1'b0, x_base} + 10'(s2_col);
    sy        = {1'b0, y_base} + 9'(s2_row);
    on_screen = (sx < 10'(FB_W)) && (sy < 9'(FB_H));
    wr_hit    = s2_valid && rom_pixel && on_screen;
    wr_addr   = 17'(sy) * 17'(FB_W) + 17'(sx);
  end

  // Framebuffer write port; address holds when no write is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we_reg    <= 1'b0;
      fb_wdata_reg <= 1'b0;
      fb_addr_reg  <= '0;
    end else begin
      fb_we_reg    <= wr_hit;
      fb_wdata_reg <= wr_hit;
      if (wr_hit) fb_addr_reg <= wr_addr;
    end
  end

  // Completion pulse, one cycle long, coincident with the return to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_reg <= 1'b0;
    else          done_reg <= done_next;
  end

  assign done     = done_reg;
  assign rom_addr = rom_addr_reg;
  assign fb_we    = fb_we_reg;
  assign fb_wdata = fb_wdata_reg;
  assign fb_addr  = fb_addr_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed testbench for sprite_blitter: a behavioural sprite ROM with one
// cycle of read latency, per-cycle expected write computed from the blit
// origin, and summary checks per blit.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic        busy;
  logic        done;
  logic [9:0]  rom_addr;
  logic        rom_pixel = 1'b0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic        fb_wdata;

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;

  sprite_blitter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_pixel (rom_pixel),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata)
  );

  always #5 clk = ~clk;

  // Sprite content: mode 0 all ones, mode 1 checkerboard (row+col odd set).
  function automatic bit pix(input int m, input int n);
    if (m == 0) return 1'b1;
    return (((n / 20) + (n % 20)) % 2) == 1;
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_pixel <= pix(rom_mode, int'(rom_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one blit from the current negedge. Start pulses at cycles p1/p2 test
  // that mid-blit requests are ignored; chain leaves start high in the done cycle.
  task automatic blit(input string name, input int m, input int bx, input int by,
                      input int exp_writes, input int exp_first, input int exp_last,
                      input int exp_faddr, input int exp_laddr,
                      input int p1, input int p2, input bit chain);
    int n_w = 0, bad_w = 0, bad_ra = 0, bad_busy = 0, n_done = 0;
    int first_w = -1, last_w = -1, done_cyc = -1;
    int first_a = -1, last_a = -1;
    int kend;
    rom_mode = m;
    x0 = 9'(bx);
    y0 = 8'(by);
    start = 1'b1;
    @(posedge clk);
    kend = chain ? 603 : 605;
    for (int k = 1; k <= kend; k++) begin
      bit exp_we;
      int exp_addr;
      @(negedge clk);
      exp_we = 1'b0;
      exp_addr = 0;
      if (k >= 3 && k <= 602) begin
        int n, sx, sy;
        n  = k - 3;
        sx = bx + n % 20;
        sy = by + n / 20;
        exp_we = pix(m, n) && sx < 320 && sy < 240;
        exp_addr = sy * 320 + sx;
      end
      if (fb_we !== exp_we) bad_w++;
      else if (exp_we && (fb_addr !== 17'(exp_addr) || fb_wdata !== 1'b1)) bad_w++;
      if (fb_we === 1'b1) begin
        n_w++;
        if (first_w < 0) begin
          first_w = k;
          first_a = int'(fb_addr);
        end
        last_w = k;
        last_a = int'(fb_addr);
      end
      if (k <= 600 && rom_addr !== 10'(k - 1)) bad_ra++;
      if (busy !== (k <= 602)) bad_busy++;
      if (done === 1'b1) begin
        if (done_cyc < 0) done_cyc = k;
        n_done++;
      end
      start = (k == p1) || (k == p2) || (chain && k == kend);
    end
    check({name, "_writes"}, n_w, exp_writes);
    check({name, "_write_errs"}, bad_w, 0);
    check({name, "_first_cycle"}, first_w, exp_first);
    check({name, "_last_cycle"}, last_w, exp_last);
    check({name, "_first_addr"}, first_a, exp_faddr);
    check({name, "_last_addr"}, last_a, exp_laddr);
    check({name, "_rom_addr_errs"}, bad_ra, 0);
    check({name, "_busy_errs"}, bad_busy, 0);
    check({name, "_done_cycle"}, done_cyc, 603);
    check({name, "_done_count"}, n_done, 1);
    $display("blit %s: mode=%0d origin=(%0d,%0d) writes=%0d done_cycle=%0d",
             name, m, bx, by, n_w, done_cyc);
  endtask

  initial begin
    int activity;
    reset_n = 1'b0;
    start = 1'b0;
    x0 = '0;
    y0 = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_wdata", fb_wdata, 0);
    reset_n = 1'b1;
    activity = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || fb_we !== 1'b0 || rom_addr !== 10'd0) activity++;
    end
    check("idle_after_reset", activity, 0);
    $display("reset: idle cycles with activity=%0d", activity);

    // Full sprite at origin, checkerboard, and a clipped corner.
    blit("ones_origin", 0, 0, 0, 600, 3, 602, 0, 9299, 0, 0, 1'b0);
    blit("checker", 1, 100, 50, 300, 4, 601, 16101, 25398, 0, 0, 1'b0);
    blit("clipped", 0, 310, 225, 150, 3, 292, 72310, 76799, 0, 0, 1'b0);

    // Mid-blit starts ignored; start in the done cycle chains a second blit.
    blit("ignore_start", 0, 0, 0, 600, 3, 602, 0, 9299, 5, 400, 1'b1);
    blit("chained", 0, 0, 0, 600, 3, 602, 0, 9299, 0, 0, 1'b0);

    // Reset in cycle 100 of a blit.
    rom_mode = 0;
    x0 = '0;
    y0 = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_abort_fb_we", fb_we, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_fb_we", fb_we, 0);
    check("abort_fb_addr", fb_addr, 0);
    check("abort_rom_addr", rom_addr, 0);
    check("abort_fb_wdata", fb_wdata, 0);
    activity = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) activity++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) activity++;
    end
    check("abort_no_done", activity, 0);
    $display("abort: reset in cycle 100, stray done/busy cycles=%0d", activity);
    blit("after_abort", 0, 0, 0, 600, 3, 602, 0, 9299, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
